// File: rtl/adc_sample_buffer_pkg.sv
// Shared widths and FIFO entry layout for the ADC capture/buffer path.
package adc_sample_buffer_pkg;

  localparam int unsigned ADC_W   = 14;
  localparam int unsigned ENTRY_W = ADC_W + 1;

  typedef struct packed {
    logic             tag;
    logic [ADC_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; head, full and valid are all registered.
module sample_fifo
  import adc_sample_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   valid_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  entry_t             head_q, head_d;
  logic               full_q, full_d;
  logic               valid_q, valid_d;
  logic               wr_en_c, rd_en_c;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    rd_en_c  = pop_i && valid_q;
    wr_en_c  = push_i && (!full_q || rd_en_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d   = cnt_q + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    valid_d = (cnt_d != '0);
    // Next head bypasses the memory when it is the entry being written now.
    head_d = '0;
    if (valid_d) begin
      if (wr_en_c && (wr_ptr_q == rd_ptr_d)) head_d = wdata_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
    end
  end

  assign head_o  = head_q;
  assign full_o  = full_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/adc_sample_buffer.sv
// Paces ADC conversions, captures samples after the ADC latency, and forwards
// them raw (fast) or block-averaged (slow) into a small show-ahead FIFO.
module adc_sample_buffer
  import adc_sample_buffer_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned ADC_LAT    = 3,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             FastSel,
  input  logic [ADC_W-1:0] AdcData,
  output logic             AdcStart,
  input  logic             ReadAck,
  output logic [ADC_W-1:0] DataSlow,
  output logic             Fast,
  output logic             ReadyBuff,
  output logic             Overrun,
  input  logic             ClearOvr
);

  localparam int unsigned TMR_W = $clog2(CLK_DIV);
  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned BLK_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((1 << AVG_LOG2) - 1);

  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               start_q, start_d;
  logic [ADC_LAT-1:0] vld_q, vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               mode_q, mode_d;
  logic               push_q, push_d;
  entry_t             entry_q, entry_d;
  logic               ovr_q, ovr_d;

  logic               cap_c, mode_c, drop_c;
  logic [ACC_W-1:0]   sum_c;
  entry_t             head;
  logic               fifo_full, fifo_valid;

  always_comb begin
    tmr_d   = '0;
    start_d = 1'b0;
    vld_d   = '0;
    acc_d   = '0;
    blk_d   = '0;
    mode_d  = mode_q;
    push_d  = 1'b0;
    entry_d = entry_q;
    cap_c   = Enable && vld_q[ADC_LAT-1];
    // The mode only follows FastSel at a block boundary.
    mode_c  = (blk_q == '0) ? FastSel : mode_q;
    sum_c   = acc_q + ACC_W'(AdcData);

    if (Enable) begin
      tmr_d   = (tmr_q == TMR_LAST) ? '0 : tmr_q + TMR_W'(1);
      start_d = (tmr_q == '0);
      vld_d   = ADC_LAT'({vld_q, start_q});
      acc_d   = acc_q;
      blk_d   = blk_q;
      if (cap_c) begin
        mode_d = mode_c;
        if (mode_c) begin
          push_d       = 1'b1;
          entry_d.tag  = 1'b1;
          entry_d.data = AdcData;
        end else if (blk_q == BLK_LAST) begin
          push_d       = 1'b1;
          entry_d.tag  = 1'b0;
          entry_d.data = ADC_W'(sum_c >> AVG_LOG2);
          acc_d        = '0;
          blk_d        = '0;
        end else begin
          acc_d = sum_c;
          blk_d = blk_q + BLK_W'(1);
        end
      end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    drop_c = push_q && fifo_full && !(ReadAck && fifo_valid);
    ovr_d  = ovr_q;
    if (drop_c)        ovr_d = 1'b1;
    else if (ClearOvr) ovr_d = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tmr_q   <= '0;
      start_q <= 1'b0;
      vld_q   <= '0;
      acc_q   <= '0;
      blk_q   <= '0;
      mode_q  <= 1'b0;
      push_q  <= 1'b0;
      entry_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      blk_q   <= blk_d;
      mode_q  <= mode_d;
      push_q  <= push_d;
      entry_q <= entry_d;
      ovr_q   <= ovr_d;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (push_q),
    .wdata_i (entry_q),
    .pop_i   (ReadAck),
    .head_o  (head),
    .full_o  (fifo_full),
    .valid_o (fifo_valid)
  );

  assign AdcStart  = start_q;
  assign DataSlow  = head.data;
  assign Fast      = head.tag;
  assign ReadyBuff = fifo_valid;
  assign Overrun   = ovr_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer with a queue-based cycle model.
module tb_adc_sample_buffer;

  localparam int unsigned CLK_DIV    = 8;
  localparam int unsigned ADC_LAT    = 3;
  localparam int unsigned AVG_LOG2   = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned N          = 1 << AVG_LOG2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        FastSel = 1'b0;
  logic [13:0] AdcData = '0;
  logic        ReadAck = 1'b0;
  logic        ClearOvr = 1'b0;
  logic        AdcStart, Fast, ReadyBuff, Overrun;
  logic [13:0] DataSlow;

  int tests = 0;
  int fails = 0;

  adc_sample_buffer #(
    .CLK_DIV    (CLK_DIV),
    .ADC_LAT    (ADC_LAT),
    .AVG_LOG2   (AVG_LOG2),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .FastSel   (FastSel),
    .AdcData   (AdcData),
    .AdcStart  (AdcStart),
    .ReadAck   (ReadAck),
    .DataSlow  (DataSlow),
    .Fast      (Fast),
    .ReadyBuff (ReadyBuff),
    .Overrun   (Overrun),
    .ClearOvr  (ClearOvr)
  );

  always #5 Clk = ~Clk;

  // Model state: timestamps of pending captures, current block samples, FIFO contents.
  longint      cyc = 0;
  int unsigned m_run;
  longint      m_capq[$];
  int unsigned m_blk[$];
  logic [14:0] m_fifo[$];
  logic [14:0] m_push_val;
  bit          m_mode, m_start, m_ovr, m_push_pend, m_cmp_en;
  bit          m_full_b, m_popped;
  int unsigned m_sum;

  always @(posedge Clk) begin
    if (Reset) begin
      m_run = 0; m_capq.delete(); m_blk.delete(); m_fifo.delete();
      m_mode = 0; m_start = 0; m_ovr = 0; m_push_pend = 0; m_cmp_en = 1;
    end else begin
      m_full_b = (m_fifo.size() == FIFO_DEPTH);
      m_popped = 0;
      if (ReadAck && m_fifo.size() > 0) begin
        void'(m_fifo.pop_front());
        m_popped = 1;
      end
      if (m_push_pend && m_full_b && !m_popped) m_ovr = 1;
      else begin
        if (m_push_pend) m_fifo.push_back(m_push_val);
        if (ClearOvr) m_ovr = 0;
      end
      m_push_pend = 0;
      if (Enable) begin
        if (m_capq.size() > 0 && m_capq[0] == cyc) begin
          void'(m_capq.pop_front());
          if (m_blk.size() == 0) m_mode = FastSel;
          if (m_mode) begin
            m_push_pend = 1;
            m_push_val  = {1'b1, AdcData};
          end else begin
            m_blk.push_back(int'(AdcData));
            if (m_blk.size() == N) begin
              m_sum = 0;
              foreach (m_blk[i]) m_sum += m_blk[i];
              m_push_pend = 1;
              m_push_val  = {1'b0, 14'(m_sum / N)};
              m_blk.delete();
            end
          end
        end
        m_start = ((m_run % CLK_DIV) == 0);
        if (m_start) m_capq.push_back(cyc + 1 + ADC_LAT);
        m_run++;
      end else begin
        m_run = 0; m_start = 0; m_capq.delete(); m_blk.delete();
      end
    end
    cyc++;
  end

  logic [17:0] exp_v, act_v;
  logic [14:0] exp_head;

  always @(negedge Clk) begin
    if (m_cmp_en) begin
      exp_head = (m_fifo.size() > 0) ? m_fifo[0] : 15'd0;
      exp_v = {m_start, (m_fifo.size() > 0), exp_head, m_ovr};
      act_v = {AdcStart, ReadyBuff, Fast, DataSlow, Overrun};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL model cycle %0d: got start=%b rb=%b fast=%b data=%0d ovr=%b, expected start=%b rb=%b fast=%b data=%0d ovr=%b",
                 cyc, AdcStart, ReadyBuff, Fast, DataSlow, Overrun,
                 exp_v[17], exp_v[16], exp_v[15], exp_v[14:1], exp_v[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1; Enable = 0; ReadAck = 0; ClearOvr = 0;
    steps(2);
    Reset = 0;
  endtask

  // Waits for the next AdcStart and presents the value that conversion will return.
  task automatic conv(input logic [13:0] v);
    bit seen = 0;
    for (int i = 0; i < 2 * CLK_DIV + 4 && !seen; i++) begin
      @(negedge Clk);
      if (AdcStart === 1'b1) seen = 1;
    end
    chk("adcstart_seen", 32'(seen), 32'd1);
    AdcData = v;
  endtask

  task automatic pop();
    ReadAck = 1;
    @(negedge Clk);
    ReadAck = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_outputs", {AdcStart, ReadyBuff, Fast, DataSlow, Overrun}, 32'd0);

    // Fast mode, constant data: pulse spacing and first-entry latency.
    FastSel = 1; AdcData = 14'h1234; Enable = 1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge Clk);
      if (k == 1 || k == 9 || k == 17) chk($sformatf("start_c%0d", k), 32'(AdcStart), 32'd1);
      if (k == 2) chk("start_c2", 32'(AdcStart), 32'd0);
      if (k == 5) chk("rb_c5", 32'(ReadyBuff), 32'd0);
      if (k == 6) begin
        chk("rb_c6", 32'(ReadyBuff), 32'd1);
        chk("data_c6", 32'(DataSlow), 32'h1234);
        chk("fast_c6", 32'(Fast), 32'd1);
      end
    end

    // Overrun: six fast samples with no reads.
    do_reset();
    FastSel = 1; Enable = 1;
    for (int v = 10; v <= 15; v++) conv(14'(v));
    steps(5);
    Enable = 0;
    chk("ovr_set", 32'(Overrun), 32'd1);
    chk("ovr_head", 32'(DataSlow), 32'd10);
    ClearOvr = 1; @(negedge Clk); ClearOvr = 0;
    chk("ovr_cleared", 32'(Overrun), 32'd0);
    Enable = 1;
    conv(14'd16);
    steps(4);
    ClearOvr = 1; @(negedge Clk); ClearOvr = 0;
    Enable = 0;
    chk("ovr_set_wins", 32'(Overrun), 32'd1);
    for (int v = 11; v <= 13; v++) begin
      pop();
      chk($sformatf("ovr_pop_%0d", v), 32'(DataSlow), 32'(v));
    end
    pop();
    chk("ovr_empty_rb", 32'(ReadyBuff), 32'd0);
    chk("ovr_empty_data", 32'(DataSlow), 32'd0);

    // Full FIFO with a pop coincident with a push.
    do_reset();
    FastSel = 1; Enable = 1;
    for (int v = 20; v <= 23; v++) conv(14'(v));
    conv(14'd24);
    steps(4);
    pop();
    Enable = 0;
    chk("full_pp_head", 32'(DataSlow), 32'd21);
    chk("full_pp_ovr", 32'(Overrun), 32'd0);
    for (int v = 22; v <= 24; v++) begin
      pop();
      chk($sformatf("full_pp_pop_%0d", v), 32'(DataSlow), 32'(v));
    end
    pop();
    chk("full_pp_empty", 32'(ReadyBuff), 32'd0);

    // Slow mode averaging, including full-scale samples.
    do_reset();
    FastSel = 0; Enable = 1;
    conv(14'd100); conv(14'd101); conv(14'd102); conv(14'd105);
    steps(5);
    chk("avg_data", 32'(DataSlow), 32'd102);
    chk("avg_fast", 32'(Fast), 32'd0);
    for (int i = 0; i < 4; i++) conv(14'd16383);
    steps(5);
    pop();
    chk("avg_max", 32'(DataSlow), 32'd16383);
    Enable = 0;

    // FastSel change mid-block does not split the block.
    do_reset();
    FastSel = 0; Enable = 1;
    conv(14'd1); conv(14'd2);
    FastSel = 1;
    conv(14'd3); conv(14'd6); conv(14'd50);
    steps(5);
    Enable = 0;
    chk("mode_blk_data", 32'(DataSlow), 32'd3);
    chk("mode_blk_fast", 32'(Fast), 32'd0);
    pop();
    chk("mode_next_data", 32'(DataSlow), 32'd50);
    chk("mode_next_fast", 32'(Fast), 32'd1);

    // Enable low mid-block discards the partial block.
    do_reset();
    FastSel = 0; Enable = 1;
    conv(14'd7); conv(14'd7); conv(14'd7);
    steps(5);
    Enable = 0;
    steps(3);
    chk("en_low_rb", 32'(ReadyBuff), 32'd0);
    Enable = 1;
    conv(14'd40); conv(14'd41); conv(14'd42); conv(14'd43);
    steps(5);
    chk("en_low_avg", 32'(DataSlow), 32'd41);
    pop();

    // Reset mid-block discards the partial block.
    conv(14'd900); conv(14'd900); conv(14'd900);
    steps(4);
    do_reset();
    chk("rst_mid_rb", 32'(ReadyBuff), 32'd0);
    Enable = 1;
    conv(14'd8); conv(14'd8); conv(14'd8); conv(14'd12);
    steps(5);
    chk("rst_mid_avg", 32'(DataSlow), 32'd9);
    Enable = 0;
    steps(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
